dev_output_port: RTL and testbench
==================================

Name: dev_output_port

Overview:
- Device-side transmitter for the 5-bit output device interface. It drives output_rdy and output_data and consumes output_ack; it is the source end of the handshake that the simulation output sink acknowledges.
- It accepts one 31-bit word from the processor: bit 30 is the sign, bits 29:0 are the magnitude.
- Each word goes out as a sign code followed by six 5-bit magnitude digits, MSB first.
- Operator start/stop pulses gate the port; output_active feeds the panel and the machine-stop detection.

Parameters:
- CODE_W, 5, width of one output code.
- NUM_DIGITS, 6, magnitude digits per word; magnitude width = CODE_W*NUM_DIGITS = 30.
- POS_CODE, 5'h1a, sign code emitted when word bit 30 = 0.
- NEG_CODE, 5'h1b, sign code emitted when word bit 30 = 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse (btn_start_output); enables the port.
- stop  in  1  one-cycle pulse (btn_stop_output); disables the port.
- stop_after_word  in  1  level (sw_stop_after_output); when high, the port deactivates after each completed word.
- word_val  in  1  processor word valid.
- word_data  in  31  processor word; [30] sign, [29:0] magnitude.
- word_rdy  out  1  port can accept a word this cycle.
- output_rdy  out  1  code on output_data is valid.
- output_data  out  5  current code.
- output_ack  in  1  sink acknowledge; may be a pulse or a held level.
- output_active  out  1  port enabled or word in flight.
- word_done  out  1  one-cycle pulse after the last code of a word is acknowledged.

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; all outputs 0.
  - Also cleared: output_data=0, the shift register, the digit counter and stop_pending.
- Transfer rule: a code is transferred on a clk edge where output_rdy=1 and output_ack=1.
  - output_data is stable for the whole time output_rdy=1.
- States (3-bit state encoding):
  - IDLE: output_active=0, word_rdy=0.
    - start=1 and stop=0 -> READY.
    - start and stop in the same cycle: stop wins, stay IDLE.
  - READY: output_active=1, word_rdy = !stop.
    - stop=1 -> IDLE; a word presented in the same cycle is not accepted.
    - word_val && word_rdy -> load shift register with word_data[29:0].
      - output_data <= word_data[30] ? NEG_CODE : POS_CODE.
      - Digit counter <= NUM_DIGITS. Go to SEND.
  - SEND: output_rdy=1. A stop pulse here sets stop_pending; the current code is never truncated.
    - On transfer -> RELEASE with output_rdy=0 on the next cycle.
  - RELEASE: output_rdy=0. A stop pulse here sets stop_pending. Waits for output_ack=0, which gives at least one gap cycle; a held ack is never double-counted. When output_ack=0:
    - stop_pending: clear it, -> IDLE. word_done is not pulsed.
    - else if counter != 0:
      - output_data <= shift[29:25]; shift <<= 5; counter--.
      - -> SEND.
    - else: word_done=1 for this cycle.
      - stop_after_word=1 -> IDLE; else -> READY.
- Latency:
  - Word accept to first output_rdy: 1 cycle.
  - Minimum code period: 2 cycles (SEND, then RELEASE) with a single-cycle ack pulse.
  - A full word is 7 codes.
- output_active = (state != IDLE).
- start pulses outside IDLE are ignored.
- Reset mid-word: the word is lost and the port restarts in IDLE; no partial resume.
- The port never accepts a new word before word_done of the previous one.

Decomposition:
- Shared package: state encoding localparams (IDLE, READY, SEND, RELEASE) and the sign code constants POS_CODE/NEG_CODE.
  - The input-side receiver reuses the same codes.
- Single module, no sub-module.
  - The shift register plus counter is small enough to stay inline.

Test Plan:
- Basic word:
  - Stimulus: start pulse, then word 31'h4000_0001; sink acks each code with a 1-cycle pulse 3 cycles after rdy.
  - Required: codes 1b,00,00,00,00,00,01, in order.
  - word_done pulses once; the port returns to READY.
- All-ones positive with level ack:
  - Stimulus: word 31'h3FFF_FFFF; ack held high for 4 cycles after each rdy.
  - Required: codes 1a,1f,1f,1f,1f,1f,1f.
  - Exactly 7 transfers; output_rdy stays 0 until ack drops.
- Stop mid-word:
  - Stimulus: stop pulse while the 3rd code is in SEND.
  - Required: the 3rd code completes its handshake, then IDLE with output_active=0.
  - No word_done; no 4th code.
- stop_after_word:
  - Stimulus: stop_after_word=1, send one word.
  - Required: after word_done, state IDLE with word_rdy=0.
  - A second word_val is not accepted until a new start pulse.
- Simultaneous events:
  - start+stop in IDLE -> stays IDLE.
  - stop+word_val in READY -> word_rdy=0, word not accepted, -> IDLE.
- Async reset mid-SEND:
  - Stimulus: resetn low mid-cycle.
  - Required: output_rdy, output_active and output_data all drop to 0 immediately, without waiting for a clk edge.
  - After release, no codes until a new start.

Source files
------------

// File: rtl/dev_output_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dev_output_port_pkg
// Description : Shared definitions for the 5-bit output device interface.
//               Holds the transmitter state encoding and the sign codes that
//               both the output port and the input-side receiver agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package dev_output_port_pkg;

  // Transmitter state encoding (explicit 3-bit width)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READY   = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;

  // Sign codes that lead every word on the device interface
  localparam logic [4:0] POS_CODE = 5'h1a;
  localparam logic [4:0] NEG_CODE = 5'h1b;

endpackage : dev_output_port_pkg
`default_nettype wire

// File: rtl/dev_output_port.sv
`default_nettype none
// ============================================================================
// Module      : dev_output_port
// Description : Device-side transmitter for the 5-bit output interface.
//               Takes one signed-magnitude word from the processor and sends
//               it as a sign code followed by NUM_DIGITS magnitude digits,
//               MSB first, over an rdy/ack four-phase style handshake.
// Ports       : clk, resetn          - clock, async active-low reset
//               start, stop          - operator pulses gating the port
//               stop_after_word      - deactivate after each completed word
//               word_val/word_data   - processor word in, word_rdy back
//               output_rdy/_data/_ack- device handshake
//               output_active        - port enabled or word in flight
//               word_done            - pulse when a whole word has gone out
// Revision    : 1.0 - initial release
// ============================================================================
module dev_output_port #(
  parameter int                CODE_W     = 5,
  parameter int                NUM_DIGITS = 6,
  parameter logic [CODE_W-1:0] POS_CODE   = dev_output_port_pkg::POS_CODE,
  parameter logic [CODE_W-1:0] NEG_CODE   = dev_output_port_pkg::NEG_CODE
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         stop_after_word,
  input  logic                         word_val,
  input  logic [CODE_W*NUM_DIGITS:0]   word_data,
  output logic                         word_rdy,
  output logic                         output_rdy,
  output logic [CODE_W-1:0]            output_data,
  input  logic                         output_ack,
  output logic                         output_active,
  output logic                         word_done
);

  import dev_output_port_pkg::*;

  localparam int MAG_W = CODE_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [CODE_W-1:0] r_data;
  logic [MAG_W-1:0]  r_shift;
  logic [CNT_W-1:0]  r_count;
  logic              r_stop_pending;

  logic w_accept;
  logic w_release_go;
  logic w_stop_req;
  logic w_next_digit;

  assign w_accept     = (r_state == READY) && word_val && !stop;
  // Gap cycle: RELEASE only advances once the sink has dropped ack, so a
  // held ack can never be counted as a second transfer.
  assign w_release_go = (r_state == RELEASE) && !output_ack;
  // A stop arriving in the very cycle RELEASE resolves still aborts the word.
  assign w_stop_req   = r_stop_pending || stop;
  assign w_next_digit = w_release_go && !w_stop_req && (r_count != '0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !stop) w_state_next = READY;
      end
      READY: begin
        if (stop)          w_state_next = IDLE;
        else if (word_val) w_state_next = SEND;
      end
      SEND: begin
        if (output_ack) w_state_next = RELEASE;
      end
      RELEASE: begin
        if (!output_ack) begin
          if (w_stop_req)             w_state_next = IDLE;
          else if (r_count != '0)     w_state_next = SEND;
          else if (stop_after_word)   w_state_next = IDLE;
          else                        w_state_next = READY;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    output_rdy    = (r_state == SEND);
    output_active = (r_state != IDLE);
    word_rdy      = (r_state == READY) && !stop;
    word_done     = w_release_go && !w_stop_req && (r_count == '0);
    output_data   = r_data;
  end

  // Code datapath: sign code on accept, then one digit per handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data         <= '0;
      r_shift        <= '0;
      r_count        <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= word_data[MAG_W-1:0];
        r_data  <= word_data[MAG_W] ? NEG_CODE : POS_CODE;
        r_count <= CNT_W'(NUM_DIGITS);
      end else if (w_next_digit) begin
        r_data  <= r_shift[MAG_W-1 -: CODE_W];
        r_shift <= r_shift << CODE_W;
        r_count <= r_count - CNT_W'(1);
      end

      // Clearing on the abort takes priority over a same-cycle stop pulse.
      if (w_release_go && w_stop_req) begin
        r_stop_pending <= 1'b0;
      end else if (stop && ((r_state == SEND) || (r_state == RELEASE))) begin
        r_stop_pending <= 1'b1;
      end
    end
  end

endmodule : dev_output_port
`default_nettype wire

// File: tb/tb_dev_output_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_dev_output_port
// Description : Self-checking bench for dev_output_port. Expected code
//               streams are computed arithmetically from each word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_output_port;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic        stop_after_word;
  logic        word_val;
  logic [30:0] word_data;
  logic        word_rdy;
  logic        output_rdy;
  logic [4:0]  output_data;
  logic        output_ack;
  logic        output_active;
  logic        word_done;

  int errors = 0;
  int checks = 0;

  logic [4:0] cap_q[$];
  int         done_cnt = 0;

  always #5 clk = ~clk;

  dev_output_port dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .stop            (stop),
    .stop_after_word (stop_after_word),
    .word_val        (word_val),
    .word_data       (word_data),
    .word_rdy        (word_rdy),
    .output_rdy      (output_rdy),
    .output_data     (output_data),
    .output_ack      (output_ack),
    .output_active   (output_active),
    .word_done       (word_done)
  );

  // Inputs change just after posedge, so the negedge view equals what the
  // next posedge sees: rdy&&ack here is exactly one transfer.
  always @(negedge clk) begin
    if (resetn) begin
      if (output_rdy && output_ack) cap_q.push_back(output_data);
      if (word_done) done_cnt++;
    end
  end

  // Reference: code k of a word (0 = sign, 1..6 = base-32 digits MSB first)
  function automatic logic [4:0] exp_code(input logic [30:0] w, input int k);
    logic [29:0] m;
    m = w[29:0];
    if (k == 0) return w[30] ? 5'h1b : 5'h1a;
    return 5'((m / (30'd1 << (5 * (6 - k)))) % 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept_word(input logic [30:0] w);
    bit got;
    got = 0;
    word_val  = 1'b1;
    word_data = w;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (word_rdy) got = 1;
      tick();
    end
    word_val = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept: word_rdy never seen, got 0 required 1");
    end
    checks++;
    if (output_rdy !== 1'b1 || output_data !== exp_code(w, 0)) begin
      errors++;
      $display("FAIL first_code_latency: rdy=%b data=%h required rdy=1 data=%h",
               output_rdy, output_data, exp_code(w, 0));
    end
  endtask

  // Sink side of one code: wait for rdy, delay, then ack for 'hold' cycles
  task automatic sink_code(input int delay, input int hold);
    int         wt;
    logic [4:0] d0;
    wt = 0;
    while (output_rdy !== 1'b1 && wt < 20) begin
      tick();
      wt++;
    end
    if (output_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: output_rdy=%b required 1", output_rdy);
      return;
    end
    d0 = output_data;
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (output_data !== d0 || output_rdy !== 1'b1) begin
        errors++;
        $display("FAIL data_stable: data=%h rdy=%b required data=%h rdy=1",
                 output_data, output_rdy, d0);
      end
    end
    output_ack = 1'b1;
    tick();
    for (int i = 1; i < hold; i++) begin
      checks++;
      if (output_rdy !== 1'b0) begin
        errors++;
        $display("FAIL rdy_during_held_ack: output_rdy=%b required 0", output_rdy);
      end
      tick();
    end
    output_ack = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [30:0] w,
                          input int delay, input int hold);
    int base, dbase;
    base  = cap_q.size();
    dbase = done_cnt;
    accept_word(w);
    for (int k = 0; k < 7; k++) sink_code(delay, hold);
    tick();
    tick();
    checks++;
    if (cap_q.size() - base !== 7) begin
      errors++;
      $display("FAIL %s transfers: got %0d required 7", name, cap_q.size() - base);
    end
    for (int k = 0; k < 7 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== exp_code(w, k)) begin
        errors++;
        $display("FAIL %s code%0d: got %h required %h", name, k,
                 cap_q[base + k], exp_code(w, k));
      end
    end
    checks++;
    if (done_cnt - dbase !== 1) begin
      errors++;
      $display("FAIL %s word_done: got %0d pulses required 1", name, done_cnt - dbase);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; stop = 1'b0; stop_after_word = 1'b0;
    word_val = 1'b0; word_data = '0; output_ack = 1'b0;
    tick();
    tick();
    checks++;
    if ({output_rdy, output_active, word_rdy, word_done, output_data} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {output_rdy, output_active, word_rdy, word_done, output_data});
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (output_active !== 1'b0 || word_rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: active=%b word_rdy=%b required 0 0",
               output_active, word_rdy);
    end
  endtask

  task automatic test_basic_word();
    pulse_start();
    run_word("basic", 31'h4000_0001, 3, 1);
    checks++;
    if (output_active !== 1'b1 || word_rdy !== 1'b1 || output_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_to_ready: active=%b word_rdy=%b rdy=%b required 1 1 0",
               output_active, word_rdy, output_rdy);
    end
  endtask

  task automatic test_level_ack();
    run_word("level_ack", 31'h3FFF_FFFF, 0, 4);
  endtask

  task automatic test_random_words();
    logic [30:0] w;
    for (int n = 0; n < 5; n++) begin
      w = 31'($urandom);
      run_word($sformatf("random%0d", n), w, int'($urandom_range(0, 3)),
               int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_stop_mid_word();
    logic [30:0] w;
    int base, dbase, wt;
    w     = 31'($urandom);
    base  = cap_q.size();
    dbase = done_cnt;
    accept_word(w);
    sink_code(1, 1);
    sink_code(0, 2);
    wt = 0;
    while (output_rdy !== 1'b1 && wt < 20) begin
      tick();
      wt++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (output_rdy !== 1'b1 || output_data !== exp_code(w, 2)) begin
      errors++;
      $display("FAIL stop_no_truncate: rdy=%b data=%h required 1 %h",
               output_rdy, output_data, exp_code(w, 2));
    end
    output_ack = 1'b1;
    tick();
    output_ack = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (output_active !== 1'b0 || output_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stop_to_idle: active=%b rdy=%b required 0 0", output_active, output_rdy);
    end
    checks++;
    if (cap_q.size() - base !== 3) begin
      errors++;
      $display("FAIL stop_code_count: got %0d required 3", cap_q.size() - base);
    end
    for (int k = 0; k < 3 && base + k < cap_q.size(); k++) begin
      checks++;
      if (cap_q[base + k] !== exp_code(w, k)) begin
        errors++;
        $display("FAIL stop_code%0d: got %h required %h", k, cap_q[base + k], exp_code(w, k));
      end
    end
    checks++;
    if (done_cnt !== dbase) begin
      errors++;
      $display("FAIL stop_no_word_done: got %0d pulses required 0", done_cnt - dbase);
    end
  endtask

  task automatic test_stop_after_word();
    int busy;
    stop_after_word = 1'b1;
    pulse_start();
    run_word("saw", 31'h2AAA_5555, 1, 1);
    checks++;
    if (output_active !== 1'b0 || word_rdy !== 1'b0) begin
      errors++;
      $display("FAIL saw_idle: active=%b word_rdy=%b required 0 0", output_active, word_rdy);
    end
    busy = 0;
    word_val  = 1'b1;
    word_data = 31'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (output_rdy || word_rdy || output_active) busy++;
    end
    word_val = 1'b0;
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL saw_no_accept: busy cycles=%0d required 0", busy);
    end
    pulse_start();
    run_word("saw_second", 31'h1234_5678, 0, 1);
    stop_after_word = 1'b0;
    checks++;
    if (output_active !== 1'b0) begin
      errors++;
      $display("FAIL saw_second_idle: active=%b required 0", output_active);
    end
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (output_active !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle: active=%b required 0", output_active);
    end
    pulse_start();
    checks++;
    if (output_active !== 1'b1 || word_rdy !== 1'b1) begin
      errors++;
      $display("FAIL start_to_ready: active=%b word_rdy=%b required 1 1",
               output_active, word_rdy);
    end
    stop      = 1'b1;
    word_val  = 1'b1;
    word_data = 31'($urandom);
    #1;
    checks++;
    if (word_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stop_masks_word_rdy: word_rdy=%b required 0", word_rdy);
    end
    tick();
    stop     = 1'b0;
    word_val = 1'b0;
    checks++;
    if (output_active !== 1'b0 || output_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stop_word_to_idle: active=%b rdy=%b required 0 0",
               output_active, output_rdy);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    pulse_start();
    accept_word(31'($urandom));
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (output_rdy !== 1'b0 || output_active !== 1'b0 || output_data !== 5'd0 ||
        word_rdy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b active=%b data=%h word_rdy=%b required 0 0 00 0",
               output_rdy, output_active, output_data, word_rdy);
    end
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      output_ack = i[0];
      tick();
      if (output_rdy || output_active) seen++;
    end
    output_ack = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_resume: active cycles=%0d required 0", seen);
    end
    pulse_start();
    run_word("after_reset", 31'h0000_0421, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_level_ack();
    test_random_words();
    test_stop_mid_word();
    test_stop_after_word();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck design still reaches a verdict
  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached, errors=%0d", errors);
    $fatal(1, "time bound");
  end

endmodule : tb_dev_output_port
`default_nettype wire
